// File: rtl/ts_frame_decoder.sv
// Per-link TS frame decoder: finds K28.5-delimited fixed-length frames, checks them, tracks lock; 2-cycle latency, no backpressure.
// Define TS_CHECKSUM_EN to require the last word's [7:0] to equal the mod-256 byte sum of the frame.
module ts_frame_decoder #(
  parameter int         FRAME_WORDS  = 7,
  parameter int         LOCK_COUNT   = 4,
  parameter int         UNLOCK_COUNT = 2,
  parameter logic [7:0] COMMA        = 8'hBC
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic [15:0] rx_d,
  input  logic [1:0]  rx_k,
  input  logic        rx_err,
  output logic [15:0] out_d,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_bad,
  output logic        locked,
  output logic [31:0] good_count,
  output logic [31:0] bad_count
);
  localparam int IW = $clog2(FRAME_WORDS);
  localparam int SW = $clog2(LOCK_COUNT + UNLOCK_COUNT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);
  localparam logic [SW-1:0] LOCK_N   = SW'(LOCK_COUNT);
  localparam logic [SW-1:0] UNLOCK_N = SW'(UNLOCK_COUNT);

  typedef enum logic [1:0] {SEEK, COLLECT, EXPECT} state_t;

  state_t        r_state, w_state_nx;
  logic [IW-1:0] r_idx, w_idx_nx;
  logic          r_emit, w_emit_nx;
  logic          r_fbad, w_fbad_nx;
  logic          w_comma, w_last_pos, w_ck_bad;
  logic          w_start, w_abort, w_fend, w_fend_bad, w_miss;
  logic          w_word_vld, w_word_last;

  logic [SW-1:0] r_good_streak, r_unl_streak, w_good_nx, w_unl_nx;
  logic          r_locked, w_locked_nx;
  logic          w_good_inc;
  logic [1:0]    w_bad_inc;
  logic [31:0]   r_good_cnt, r_bad_cnt;
  logic [32:0]   w_good_sum, w_bad_sum;

  logic          r_h_vld, r_h_sof, r_h_last, r_h_bad;
  logic [15:0]   r_h_d;
  logic          r_out_vld, r_out_sof, r_out_eof, r_out_bad;
  logic [15:0]   r_out_d;

  assign w_comma    = (rx_k == 2'b01) && (rx_d[7:0] == COMMA);
  assign w_last_pos = (r_idx == LAST_IDX);

`ifdef TS_CHECKSUM_EN
  logic [7:0] r_csum;

  // Running sum seeded with the bunch counter, then both bytes of each non-final payload word.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= rx_d[15:8];
    end else if (r_state == COLLECT && !w_last_pos) begin
      r_csum <= r_csum + rx_d[15:8] + rx_d[7:0];
    end
  end

  assign w_ck_bad = (rx_d[7:0] != r_csum);
`else
  assign w_ck_bad = 1'b0;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_emit_nx   = r_emit;
    w_fbad_nx   = r_fbad;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_fend      = 1'b0;
    w_fend_bad  = 1'b0;
    w_miss      = 1'b0;
    w_word_vld  = 1'b0;
    w_word_last = 1'b0;
    case (r_state)
      SEEK: begin
        if (w_comma) w_start = 1'b1;
      end
      COLLECT: begin
        if (w_comma) begin
          w_abort    = 1'b1;
          w_fend     = 1'b1;
          w_fend_bad = 1'b1;
          w_start    = 1'b1;
        end else begin
          w_word_vld = r_emit;
          w_fbad_nx  = r_fbad | rx_err | (|rx_k);
          if (w_last_pos) begin
            w_word_last = 1'b1;
            w_fend      = 1'b1;
            w_fend_bad  = w_fbad_nx | w_ck_bad;
            w_state_nx  = EXPECT;
          end else begin
            w_idx_nx = r_idx + IW'(1);
          end
        end
      end
      EXPECT: begin
        if (w_comma) begin
          w_start = 1'b1;
        end else begin
          w_miss     = 1'b1;
          w_state_nx = SEEK;
        end
      end
      default: w_state_nx = SEEK;
    endcase
    // Emission is decided once, on the lock state seen by the comma word.
    if (w_start) begin
      w_state_nx = COLLECT;
      w_idx_nx   = IW'(1);
      w_emit_nx  = r_locked;
      w_fbad_nx  = rx_err;
      w_word_vld = r_locked;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_state <= SEEK;
      r_idx   <= '0;
      r_emit  <= 1'b0;
      r_fbad  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_emit  <= w_emit_nx;
      r_fbad  <= w_fbad_nx;
    end
  end

  // A frame end is applied before an alignment miss in the same cycle.
  always_comb begin
    w_good_nx   = r_good_streak;
    w_unl_nx    = r_unl_streak;
    w_locked_nx = r_locked;
    w_good_inc  = 1'b0;
    w_bad_inc   = 2'd0;
    if (w_fend) begin
      if (w_fend_bad) begin
        w_bad_inc = w_bad_inc + 2'd1;
        w_good_nx = '0;
        if (w_unl_nx != UNLOCK_N) w_unl_nx = w_unl_nx + SW'(1);
        if (w_unl_nx == UNLOCK_N) w_locked_nx = 1'b0;
      end else begin
        w_good_inc = 1'b1;
        w_unl_nx   = '0;
        if (w_good_nx != LOCK_N) w_good_nx = w_good_nx + SW'(1);
        if (w_good_nx == LOCK_N) w_locked_nx = 1'b1;
      end
    end
    if (w_miss) begin
      w_bad_inc = w_bad_inc + 2'd1;
      w_good_nx = '0;
      if (w_unl_nx != UNLOCK_N) w_unl_nx = w_unl_nx + SW'(1);
      if (w_unl_nx == UNLOCK_N) w_locked_nx = 1'b0;
    end
  end

  assign w_good_sum = {1'b0, r_good_cnt} + {32'd0, w_good_inc};
  assign w_bad_sum  = {1'b0, r_bad_cnt} + {31'd0, w_bad_inc};

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_good_streak <= '0;
      r_unl_streak  <= '0;
      r_locked      <= 1'b0;
      r_good_cnt    <= '0;
      r_bad_cnt     <= '0;
    end else begin
      r_good_streak <= w_good_nx;
      r_unl_streak  <= w_unl_nx;
      r_locked      <= w_locked_nx;
      r_good_cnt    <= w_good_sum[32] ? 32'hFFFF_FFFF : w_good_sum[31:0];
      r_bad_cnt     <= w_bad_sum[32]  ? 32'hFFFF_FFFF : w_bad_sum[31:0];
    end
  end

  // Holding stage: eof/bad land on the held word once the current word decides the frame's fate.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_h_vld   <= 1'b0;
      r_h_d     <= '0;
      r_h_sof   <= 1'b0;
      r_h_last  <= 1'b0;
      r_h_bad   <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_d   <= '0;
      r_out_sof <= 1'b0;
      r_out_eof <= 1'b0;
      r_out_bad <= 1'b0;
    end else begin
      r_out_vld <= r_h_vld;
      r_out_d   <= r_h_vld ? r_h_d : '0;
      r_out_sof <= r_h_vld & r_h_sof;
      r_out_eof <= r_h_vld & (r_h_last | w_abort);
      r_out_bad <= r_h_vld & ((r_h_last & r_h_bad) | w_abort);
      r_h_vld   <= w_word_vld;
      r_h_d     <= rx_d;
      r_h_sof   <= w_start;
      r_h_last  <= w_word_last;
      r_h_bad   <= w_word_last & w_fend_bad;
    end
  end

  assign out_d      = r_out_d;
  assign out_valid  = r_out_vld;
  assign out_sof    = r_out_sof;
  assign out_eof    = r_out_eof;
  assign out_bad    = r_out_bad;
  assign locked     = r_locked;
  assign good_count = r_good_cnt;
  assign bad_count  = r_bad_cnt;

endmodule

// File: tb/tb_ts_frame_decoder.sv
// Directed bench for ts_frame_decoder: lock acquisition/loss, emission, abort, alignment miss, reset, checksum.
module tb_ts_frame_decoder;
  localparam int FW = 7;

  logic        rx_clk = 1'b0;
  logic        reset;
  logic [15:0] rx_d;
  logic [1:0]  rx_k;
  logic        rx_err;
  logic [15:0] out_d;
  logic        out_valid, out_sof, out_eof, out_bad, locked;
  logic [31:0] good_count, bad_count;

  ts_frame_decoder dut (
    .rx_clk(rx_clk), .reset(reset), .rx_d(rx_d), .rx_k(rx_k), .rx_err(rx_err),
    .out_d(out_d), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_bad(out_bad), .locked(locked), .good_count(good_count), .bad_count(bad_count)
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] d; logic sof; logic eof; logic bad; int cyc; } ev_t;
  typedef struct { logic [15:0] d; int cyc; } exp_t;
  ev_t  mon[$];
  exp_t expq[$];

  always @(negedge rx_clk) begin
    if (out_valid === 1'b1) mon.push_back('{out_d, out_sof, out_eof, out_bad, cyc});
  end

  int n_cmp = 0;
  int n_err = 0;
  logic        snap_locked, pre_locked;
  logic [31:0] snap_good, snap_bad, pre_good, pre_bad;
  int          last_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic [1:0] k, input logic e, input bit emit);
    @(negedge rx_clk);
    snap_locked = locked;
    snap_good   = good_count;
    snap_bad    = bad_count;
    rx_d = d; rx_k = k; rx_err = e;
    if (emit) expq.push_back('{d, cyc + 2});
  endtask

  // Frame of n words; the last word (if reached) carries the correct byte checksum.
  task automatic send_frame(input logic [7:0] bc, input int err_at, input int n, input bit emit);
    logic [7:0]  s;
    logic [15:0] w;
    s = bc;
    send_word({bc, 8'hBC}, 2'b01, err_at == 0, emit);
    pre_locked = snap_locked;
    pre_good   = snap_good;
    pre_bad    = snap_bad;
    for (int i = 1; i < n; i++) begin
      if (i == FW - 1) begin
        w = {8'hC5, s};
      end else begin
        w = {bc ^ 8'h5A, 8'(i * 17)};
        s = s + w[15:8] + w[7:0];
      end
      send_word(w, 2'b00, err_at == i, emit);
    end
  endtask

  task automatic chk_frame(input string tag, input int n, input logic bad);
    ev_t  ev;
    exp_t ex;
    check_eq({tag, ".avail"}, 32'((mon.size() >= n) && (expq.size() >= n)), 32'd1);
    if (mon.size() >= n && expq.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        ev = mon.pop_front();
        ex = expq.pop_front();
        check_eq($sformatf("%s.d%0d", tag, i), 32'(ev.d), 32'(ex.d));
        check_eq($sformatf("%s.lat%0d", tag, i), ev.cyc, ex.cyc);
        check_eq($sformatf("%s.tag%0d", tag, i), 32'({ev.sof, ev.eof, ev.bad}),
                 32'({i == 0, i == n - 1, bad && (i == n - 1)}));
        last_cyc = ev.cyc;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ckf [0:6];
    int          n_eof;
    logic [31:0] exp_ga, exp_ba, exp_gb, exp_bb;

    reset = 1'b1; rx_d = '0; rx_k = '0; rx_err = 1'b0;
    repeat (3) @(negedge rx_clk);
    check_eq("rst.valid", 32'(out_valid), 0);
    check_eq("rst.flags", 32'({out_sof, out_eof, out_bad}), 0);
    check_eq("rst.d", 32'(out_d), 0);
    check_eq("rst.locked", 32'(locked), 0);
    check_eq("rst.good", good_count, 0);
    check_eq("rst.bad", bad_count, 0);
    reset = 1'b0;

    for (int b = 0; b < 4; b++) send_frame(8'(b), -1, FW, 1'b0);
    send_frame(8'd4, -1, FW, 1'b1);
    check_eq("lock4.locked", 32'(pre_locked), 1);
    check_eq("lock4.good", pre_good, 4);
    check_eq("lock4.bad", pre_bad, 0);

    send_frame(8'd5, 3, FW, 1'b1);
    check_eq("f5.pre_good", pre_good, 5);
    chk_frame("f4", FW, 1'b0);
    check_eq("f4.sof_word", 32'(expq.size() > 0 ? 16'h04BC : 16'h0), 32'h04BC);

    send_frame(8'd6, 2, FW, 1'b1);
    check_eq("bad1.locked", 32'(pre_locked), 1);
    check_eq("bad1.bad", pre_bad, 1);
    send_frame(8'd7, -1, FW, 1'b0);
    check_eq("bad2.locked", 32'(pre_locked), 0);
    check_eq("bad2.bad", pre_bad, 2);
    chk_frame("f5", FW, 1'b1);
    chk_frame("f6", FW, 1'b1);

    for (int b = 8; b < 11; b++) send_frame(8'(b), -1, FW, 1'b0);
    check_eq("unlocked.noemit", mon.size(), 0);

    send_frame(8'd11, -1, 4, 1'b1);
    check_eq("relock.locked", 32'(pre_locked), 1);
    check_eq("relock.good", pre_good, 9);
    send_frame(8'd12, -1, FW, 1'b1);
    check_eq("abort.pre_bad", pre_bad, 2);
    chk_frame("abort", 4, 1'b1);
    check_eq("abort.next_sof", 32'(mon.size() > 0 && mon[0].sof && mon[0].cyc == last_cyc + 1), 1);

    send_word(16'h1234, 2'b00, 1'b0, 1'b0);
    check_eq("abort.bad", snap_bad, 3);
    check_eq("abort.good", snap_good, 10);
    send_word(16'h00BC, 2'b10, 1'b0, 1'b0);
    check_eq("miss.bad", snap_bad, 4);
    send_word(16'hBC00, 2'b01, 1'b0, 1'b0);
    send_word(16'h5555, 2'b00, 1'b1, 1'b0);
    check_eq("seek.bad", snap_bad, 4);
    check_eq("seek.locked", 32'(snap_locked), 1);
    chk_frame("f12", FW, 1'b0);

    send_frame(8'd13, -1, FW, 1'b1);
    check_eq("resume.bad", pre_bad, 4);
    send_frame(8'd14, -1, 4, 1'b1);
    check_eq("resume.good", pre_good, 11);

    @(negedge rx_clk);
    reset = 1'b1; rx_d = '0; rx_k = '0; rx_err = 1'b0;
    @(negedge rx_clk);
    check_eq("mrst.valid", 32'(out_valid), 0);
    check_eq("mrst.flags", 32'({out_sof, out_eof, out_bad}), 0);
    check_eq("mrst.d", 32'(out_d), 0);
    check_eq("mrst.locked", 32'(locked), 0);
    check_eq("mrst.good", good_count, 0);
    check_eq("mrst.bad", bad_count, 0);
    @(negedge rx_clk);
    reset = 1'b0;
    repeat (4) @(negedge rx_clk);
    chk_frame("f13", FW, 1'b0);
    n_eof = 0;
    foreach (mon[i]) if (mon[i].eof) n_eof++;
    check_eq("mrst.no_eof", n_eof, 0);
    mon.delete();
    expq.delete();

    // Checksum frames: bytes 01..08 + 26 + bunch 10 sum to 5A.
    ckf = '{16'h10BC, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h0026, 16'h005B};
`ifdef TS_CHECKSUM_EN
    exp_ga = 0; exp_ba = 1; exp_gb = 1; exp_bb = 1;
`else
    exp_ga = 1; exp_ba = 0; exp_gb = 2; exp_bb = 0;
`endif
    for (int i = 0; i < FW; i++) send_word(ckf[i], (i == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0);
    ckf[6] = 16'h005A;
    for (int i = 0; i < FW; i++) begin
      send_word(ckf[i], (i == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      if (i == 0) begin
        check_eq("ck5b.good", snap_good, exp_ga);
        check_eq("ck5b.bad", snap_bad, exp_ba);
      end
    end
    send_word(16'h0000, 2'b00, 1'b0, 1'b0);
    check_eq("ck5a.good", snap_good, exp_gb);
    check_eq("ck5a.bad", snap_bad, exp_bb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
